seq_divider16by8: RTL and testbench
===================================

Name: seq_divider16by8

Overview:
- Sequential restoring divider; the inverse operation of the team's 8x8 multipliers. Divides a 2*DW-bit dividend (a product word) by a DW-bit divisor.
- Produces a DW-bit quotient and a DW-bit remainder.
- Used in the evolution bench to recover an operand from a multiplier product, which exposes approximation error.
- Valid/ready on input and output; one operation in flight at a time.

Parameters:
- DW, 8, divisor/quotient/remainder width; dividend is 2*DW bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept an operation
- dividend  input  2*DW  numerator, unsigned
- divisor  input  DW  denominator, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  DW  unsigned quotient
- remainder  output  DW  unsigned remainder
- err_div0  output  1  divisor was zero
- err_ovf  output  1  quotient would not fit in DW bits

Behaviour:
- Clocking and reset
  - One clock (clk); reset is synchronous and active-high (rst).
  - On rst: state=IDLE; in_ready=1; out_valid=0; quotient, remainder, err_div0, err_ovf = 0; internal registers cleared.
  - rst overrides every other input in the same cycle.
  - rst mid-RUN or mid-DONE discards the operation; no result is ever emitted for it.
- States
  - IDLE: in_ready=1.
  - RUN: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Accept edge
  - An operation is accepted on an edge where state is IDLE and in_valid=1.
  - The block captures dividend and divisor on that edge.
  - Decisions at the accept edge, in priority order:
    1. divisor==0 -> DONE; err_div0=1, err_ovf=0, quotient={DW{1}}, remainder=dividend[DW-1:0].
    2. dividend[2DW-1:DW] >= divisor -> DONE; err_ovf=1, err_div0=0, quotient={DW{1}}, remainder=0.
    3. Otherwise -> RUN; partial remainder R (DW+1 bits) = dividend[2DW-1:DW]; low shift register = dividend[DW-1:0]; step counter = DW-1.
- RUN step, one quotient bit per edge, MSB first
  - R' = {R[DW-1:0], next dividend bit}.
  - If R' >= divisor: R = R' - divisor and the quotient bit is 1; else R = R' and the quotient bit is 0.
  - On the step where the counter is 0: state -> DONE, out_valid=1, error flags=0.
  - Otherwise the counter decrements.
- Latency
  - Normal operation: out_valid is first high DW cycles after the accept edge (8 for the default).
  - Error operation: out_valid is high 1 cycle after the accept edge.
- DONE and output handshake
  - quotient, remainder and the error flags are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_valid && out_ready: state -> IDLE, out_valid=0.
  - Output values hold their last value after the transfer.
  - in_ready returns to 1 in the cycle after the transfer; there is no same-cycle accept/complete overlap.
  - in_valid is ignored outside IDLE; no input buffering.
- Invariant: for every non-error result, quotient*divisor + remainder == dividend and remainder < divisor.
  - Arithmetic is unsigned.
  - The compare/subtract is DW+1 bits wide, so the R' carry bit is honoured.

Optional Feature:
- Macro: DIV_FAST_ZERO_EN.
- Defined: an accepted operation with dividend==0 and divisor!=0 goes directly to DONE.
  - Result: quotient=0, remainder=0, flags 0.
  - out_valid is high 1 cycle after the accept edge.
- Undefined: a zero dividend takes the normal DW-step RUN path.
  - Result is the same (0, 0).
  - Latency is DW cycles.
- Error checks keep priority over the fast-zero path in both builds.

Test Plan:
- dividend=0xB627 (211*221), divisor=0xDD, out_ready=1 -> quotient=0xD3, remainder=0x00, flags 0; out_valid exactly 8 cycles after the accept edge; in_ready=0 during RUN.
- dividend=0x03E8 (1000), divisor=0x07 -> quotient=0x8E, remainder=0x06. Also dividend=0x04FF, divisor=0x05 -> quotient=0xFF, remainder=0x04, err_ovf=0.
- divisor=0x00, dividend=0x1234 -> err_div0=1, quotient=0xFF, remainder=0x34, 1-cycle latency. Then dividend=0x0500, divisor=0x05 -> err_ovf=1, quotient=0xFF, remainder=0x00.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid and inputs.
  - Required: outputs stable, in_ready=0, no new accept.
  - Raising out_ready completes the transfer; in_ready=1 on the next cycle.
- rst pulsed 3 cycles into RUN -> next cycle state IDLE, in_ready=1, out_valid=0, outputs 0. A following op, 0x0064/0x0A, returns quotient=0x0A, remainder=0x00.
- dividend=0x0000, divisor=0x09 -> quotient=0, remainder=0. Latency is 1 cycle with DIV_FAST_ZERO_EN and 8 cycles without.
- Random sweep of all exact products A*B with B!=0 -> quotient==A, remainder==0.

Source files
------------

// File: rtl/seq_divider16by8.sv
// Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit per clock.
// Optional macro DIV_FAST_ZERO_EN: a zero dividend with a non-zero divisor completes at the accept edge.
module seq_divider16by8 #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            err_div0,
    output logic            err_ovf
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_rem;
    logic [DW-1:0]   r_low;
    logic [DW-1:0]   r_divisor;
    logic [CW-1:0]   r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [DW-1:0]   r_quotient;
    logic [DW-1:0]   r_remainder;
    logic            r_err_div0;
    logic            r_err_ovf;

    logic [DW:0]     w_shift;
    logic            w_ge;
    logic [DW-1:0]   w_rem_next;
    logic [DW-1:0]   w_quot_next;
    logic [DW-1:0]   w_hi;

    // The shifted partial remainder keeps its carry bit so the compare is DW+1 bits wide;
    // the difference always fits in DW bits because it is below the divisor.
    assign w_shift     = {r_rem, r_low[DW-1]};
    assign w_ge        = (w_shift >= {1'b0, r_divisor});
    assign w_rem_next  = w_ge ? (w_shift[DW-1:0] - r_divisor) : w_shift[DW-1:0];
    // Quotient bits fill the low register as dividend bits are consumed from its top.
    assign w_quot_next = {r_low[DW-2:0], w_ge};
    assign w_hi        = dividend[2*DW-1:DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_low       <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_err_div0  <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_divisor <= divisor;
                        if (divisor == '0) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= dividend[DW-1:0];
                            r_err_div0  <= 1'b1;
                            r_err_ovf   <= 1'b0;
                        end else if (w_hi >= divisor) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_err_div0  <= 1'b0;
                            r_err_ovf   <= 1'b1;
`ifdef DIV_FAST_ZERO_EN
                        end else if (dividend == '0) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_quotient  <= '0;
                            r_remainder <= '0;
                            r_err_div0  <= 1'b0;
                            r_err_ovf   <= 1'b0;
`endif
                        end else begin
                            r_state    <= S_RUN;
                            r_in_ready <= 1'b0;
                            r_rem      <= w_hi;
                            r_low      <= dividend[DW-1:0];
                            r_cnt      <= CW'(DW - 1);
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_low <= w_quot_next;
                    if (r_cnt == '0) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_quotient  <= w_quot_next;
                        r_remainder <= w_rem_next;
                        r_err_div0  <= 1'b0;
                        r_err_ovf   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign err_div0  = r_err_div0;
    assign err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_seq_divider16by8.sv
// Directed self-checking bench for seq_divider16by8 (handles both DIV_FAST_ZERO_EN builds).
module tb_seq_divider16by8;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        err_div0;
    logic        err_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_divider16by8 #(.DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .err_div0  (err_div0),
        .err_ovf   (err_ovf)
    );

    // Launch one operation from IDLE; lat = edges after the accept edge until out_valid is seen.
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                          output int lat, output bit saw_ready);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        lat       = 0;
        saw_ready = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) saw_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        $display("op %h / %h -> q=%h r=%h div0=%b ovf=%b lat=%0d",
                 dvd, dvs, quotient, remainder, err_div0, err_ovf, lat);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if ({quotient, remainder, err_div0, err_ovf} !== 18'h0)
            begin n_bad++; $display("FAIL reset_outputs got q=%h r=%h d0=%b ov=%b want 0", quotient, remainder, err_div0, err_ovf); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_exact();
        int lat; bit sr;
        run_op(16'hB627, 8'hDD, lat, sr);
        n_cmp++; if (quotient !== 8'hD3) begin n_bad++; $display("FAIL exact_q got %h want d3", quotient); end
        n_cmp++; if (remainder !== 8'h00) begin n_bad++; $display("FAIL exact_r got %h want 00", remainder); end
        n_cmp++; if ({err_div0, err_ovf} !== 2'b00) begin n_bad++; $display("FAIL exact_flags got %b%b want 00", err_div0, err_ovf); end
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL exact_latency got %0d want 8", lat); end
        n_cmp++; if (sr !== 1'b0) begin n_bad++; $display("FAIL exact_in_ready_run got high want low"); end
        take_result();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin n_bad++; $display("FAIL exact_release got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_normal();
        logic [15:0] t_dvd [5] = '{16'h03E8, 16'h04FF, 16'h00FF, 16'h7FFF, 16'hFEFF};
        logic [7:0]  t_dvs [5] = '{8'h07,   8'h05,   8'h10,   8'h80,   8'hFF};
        logic [7:0]  t_q   [5] = '{8'h8E,   8'hFF,   8'h0F,   8'hFF,   8'hFF};
        logic [7:0]  t_r   [5] = '{8'h06,   8'h04,   8'h0F,   8'h7F,   8'hFE};
        int lat; bit sr;
        for (int i = 0; i < 5; i++) begin
            run_op(t_dvd[i], t_dvs[i], lat, sr);
            n_cmp++; if (quotient !== t_q[i] || remainder !== t_r[i])
                begin n_bad++; $display("FAIL normal_%0d got q=%h r=%h want q=%h r=%h", i, quotient, remainder, t_q[i], t_r[i]); end
            n_cmp++; if ({err_div0, err_ovf} !== 2'b00 || lat !== 8)
                begin n_bad++; $display("FAIL normal_%0d_flags got d0=%b ov=%b lat=%0d want 0 0 8", i, err_div0, err_ovf, lat); end
            take_result();
        end
    endtask

    task automatic test_errors();
        int lat; bit sr;
        run_op(16'h1234, 8'h00, lat, sr);
        n_cmp++; if ({err_div0, err_ovf} !== 2'b10) begin n_bad++; $display("FAIL div0_flags got %b%b want 10", err_div0, err_ovf); end
        n_cmp++; if (quotient !== 8'hFF || remainder !== 8'h34)
            begin n_bad++; $display("FAIL div0_result got q=%h r=%h want ff 34", quotient, remainder); end
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL div0_latency got %0d extra edges want 0", lat); end
        take_result();
        run_op(16'h0500, 8'h05, lat, sr);
        n_cmp++; if ({err_div0, err_ovf} !== 2'b01) begin n_bad++; $display("FAIL ovf_flags got %b%b want 01", err_div0, err_ovf); end
        n_cmp++; if (quotient !== 8'hFF || remainder !== 8'h00)
            begin n_bad++; $display("FAIL ovf_result got q=%h r=%h want ff 00", quotient, remainder); end
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL ovf_latency got %0d extra edges want 0", lat); end
        take_result();
    endtask

    task automatic test_backpressure();
        int lat; bit sr;
        run_op(16'h03E8, 8'h07, lat, sr);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            dividend = 16'h1234 + 16'(i);
            divisor  = 8'(i);
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
                begin n_bad++; $display("FAIL bp_hold_%0d got vld=%b rdy=%b want 1/0", i, out_valid, in_ready); end
            n_cmp++; if (quotient !== 8'h8E || remainder !== 8'h06 || {err_div0, err_ovf} !== 2'b00)
                begin n_bad++; $display("FAIL bp_stable_%0d got q=%h r=%h want 8e 06", i, quotient, remainder); end
        end
        in_valid = 1'b0;
        take_result();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_bad++; $display("FAIL bp_release got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
        n_cmp++; if (quotient !== 8'h8E || remainder !== 8'h06)
            begin n_bad++; $display("FAIL bp_hold_after got q=%h r=%h want 8e 06", quotient, remainder); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_bad++; $display("FAIL bp_no_accept got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid_run();
        int lat; bit sr; bit leaked;
        in_valid = 1'b1; dividend = 16'hB627; divisor = 8'hDD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin n_bad++; $display("FAIL rst_run_state got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
        n_cmp++; if ({quotient, remainder, err_div0, err_ovf} !== 18'h0)
            begin n_bad++; $display("FAIL rst_run_outputs got q=%h r=%h want 0", quotient, remainder); end
        leaked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) leaked = 1'b1;
        end
        n_cmp++; if (leaked !== 1'b0) begin n_bad++; $display("FAIL rst_run_discard got out_valid=1 want 0"); end
        run_op(16'h0064, 8'h0A, lat, sr);
        n_cmp++; if (quotient !== 8'h0A || remainder !== 8'h00 || lat !== 8)
            begin n_bad++; $display("FAIL rst_run_next got q=%h r=%h lat=%0d want 0a 00 8", quotient, remainder, lat); end
        take_result();
    endtask

    task automatic test_zero_dividend();
        int lat; bit sr; int exp_lat;
`ifdef DIV_FAST_ZERO_EN
        exp_lat = 0;
`else
        exp_lat = 8;
`endif
        run_op(16'h0000, 8'h09, lat, sr);
        n_cmp++; if (quotient !== 8'h00 || remainder !== 8'h00 || {err_div0, err_ovf} !== 2'b00)
            begin n_bad++; $display("FAIL zero_result got q=%h r=%h d0=%b ov=%b want 0", quotient, remainder, err_div0, err_ovf); end
        n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL zero_latency got %0d want %0d", lat, exp_lat); end
        take_result();
    endtask

    task automatic test_back_to_back();
        int lat; bit sr;
        logic [7:0]  a, b;
        logic [15:0] p;
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom_range(1, 255));
            b = 8'($urandom_range(1, 255));
            p = 16'(a) * 16'(b);
            run_op(p, b, lat, sr);
            n_cmp++; if (quotient !== a || remainder !== 8'h00 || lat !== 8 || {err_div0, err_ovf} !== 2'b00)
                begin n_bad++; $display("FAIL sweep_%0d got q=%h r=%h lat=%0d want q=%h r=00 lat=8", i, quotient, remainder, lat, a); end
            take_result();
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_normal();
        test_errors();
        test_backpressure();
        test_reset_mid_run();
        test_zero_dividend();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
